// File: rtl/mem_stage_lsu_pkg.sv
// Pipeline buffer register types shared by the EX, MEM and WB stages,
// plus load/store unit state, access-size codes and helpers.
package Pipe_Buf_Reg_PKG;

  typedef struct packed {
    logic        RegWrite;
    logic        MemtoReg;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  func3;
    logic [4:0]  RDest;
    logic [31:0] Alu_Result;
    logic [31:0] RD_Two;
  } ex_mem_reg;

  typedef struct packed {
    logic        RegWrite;
    logic        MemtoReg;
    logic [4:0]  RDest;
    logic [31:0] Alu_Result;
    logic [31:0] MemReadData;
  } mem_wb_reg;

  typedef enum logic {LSU_IDLE, LSU_BUSY} lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic mem_wb_reg to_wb(input ex_mem_reg e);
    mem_wb_reg w;
    w.RegWrite    = e.RegWrite;
    w.MemtoReg    = e.MemtoReg;
    w.RDest       = e.RDest;
    w.Alu_Result  = e.Alu_Result;
    w.MemReadData = '0;
    return w;
  endfunction

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic m;
    case (f3)
      F3_B, F3_BU: m = 1'b0;
      F3_H, F3_HU: m = a[0];
      default:     m = (a != 2'b00);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_lane_align.sv
// Sub-word lane handling: byte enables, store replication,
// load lane extraction with sign/zero extension.
module lsu_lane_align
  import Pipe_Buf_Reg_PKG::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  addr,
  input  logic [31:0] st_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic        is_b;
  logic        is_h;
  logic        sx;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign is_b   = (func3 == F3_B) | (func3 == F3_BU);
  assign is_h   = (func3 == F3_H) | (func3 == F3_HU);
  assign sx     = ~func3[2];
  assign byte_v = rdata[{addr, 3'b000} +: 8];
  assign half_v = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be      = 4'hF;
    wdata   = st_data;
    ld_data = rdata;
    unique case (1'b1)
      is_b: begin
        be      = 4'b0001 << addr;
        wdata   = {4{st_data[7:0]}};
        ld_data = {{24{sx & byte_v[7]}}, byte_v};
      end
      is_h: begin
        be      = 4'b0011 << {addr[1], 1'b0};
        wdata   = {2{st_data[15:0]}};
        ld_data = {{16{sx & half_v[15]}}, half_v};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM stage: data-memory bus master and MEM/WB register.
// Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN.
module mem_stage_lsu
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  ex_mem_reg         ex_mem_i,
  input  logic              ex_mem_valid_i,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ack_i,
  output mem_wb_reg         mem_wb_o,
  output logic              mem_wb_valid_o
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic              misalign_o
`endif
);

  lsu_state_e        state, state_d;
  ex_mem_reg         req_q, req_d;
  mem_wb_reg         wb_d;
  logic              wbv_d;
  logic              req_o_d;
  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [3:0]        be_d;
  logic [31:0]       wdata_d;
  logic              memop;
  logic              mis;
  logic              mis_d;
  logic              busy;
  logic [2:0]        la_f3;
  logic [1:0]        la_a;
  logic [31:0]       la_sd;
  logic [3:0]        la_be;
  logic [31:0]       la_wdata;
  logic [31:0]       la_ld;

  assign memop = ex_mem_valid_i & (ex_mem_i.MemRead | ex_mem_i.MemWrite);
  assign busy  = (state == LSU_BUSY);

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = memop & misaligned(ex_mem_i.func3, ex_mem_i.Alu_Result[1:0]);
`else
  assign mis = 1'b0;
`endif

  // Idle cycles align the incoming request; busy cycles align the read word.
  assign la_f3 = busy ? req_q.func3 : ex_mem_i.func3;
  assign la_a  = busy ? req_q.Alu_Result[1:0] : ex_mem_i.Alu_Result[1:0];
  assign la_sd = busy ? req_q.RD_Two : ex_mem_i.RD_Two;

  lsu_lane_align u_align (
    .func3   (la_f3),
    .addr    (la_a),
    .st_data (la_sd),
    .rdata   (mem_rdata_i),
    .be      (la_be),
    .wdata   (la_wdata),
    .ld_data (la_ld)
  );

  always_comb begin
    state_d = state;
    stall_o = 1'b0;
    req_d   = req_q;
    wb_d    = mem_wb_o;
    wbv_d   = 1'b0;
    req_o_d = mem_req_o;
    we_d    = mem_we_o;
    addr_d  = mem_addr_o;
    be_d    = mem_be_o;
    wdata_d = mem_wdata_o;
    mis_d   = 1'b0;
    unique case (state)
      LSU_IDLE: begin
        if (memop && !mis) begin
          stall_o = 1'b1;
          state_d = LSU_BUSY;
          req_d   = ex_mem_i;
          req_o_d = 1'b1;
          we_d    = ex_mem_i.MemWrite;
          addr_d  = {ex_mem_i.Alu_Result[ADDR_W-1:2], 2'b00};
          be_d    = ex_mem_i.MemWrite ? la_be : 4'hF;
          wdata_d = la_wdata;
        end else begin
          wb_d          = to_wb(ex_mem_i);
          wb_d.RegWrite = ex_mem_i.RegWrite & ex_mem_valid_i & ~mis;
          wbv_d         = ex_mem_valid_i;
          mis_d         = mis;
        end
      end
      LSU_BUSY: begin
        stall_o = ~mem_ack_i;
        if (mem_ack_i) begin
          wb_d             = to_wb(req_q);
          wb_d.MemReadData = (req_q.MemRead & ~req_q.MemWrite) ? la_ld : '0;
          wbv_d            = 1'b1;
          req_o_d          = 1'b0;
          state_d          = LSU_IDLE;
        end
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= LSU_IDLE;
      req_q          <= '0;
      mem_wb_o       <= '0;
      mem_wb_valid_o <= 1'b0;
      mem_req_o      <= 1'b0;
      mem_we_o       <= 1'b0;
      mem_addr_o     <= '0;
      mem_be_o       <= '0;
      mem_wdata_o    <= '0;
    end else begin
      state          <= state_d;
      req_q          <= req_d;
      mem_wb_o       <= wb_d;
      mem_wb_valid_o <= wbv_d;
      mem_req_o      <= req_o_d;
      mem_we_o       <= we_d;
      mem_addr_o     <= addr_d;
      mem_be_o       <= be_d;
      mem_wdata_o    <= wdata_d;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) misalign_o <= 1'b0;
    else        misalign_o <= mis_d;
  end
`else
  logic unused_mis;
  assign unused_mis = mis_d;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: directed ALU, load/store,
// reset-abort and misalignment cases.
module tb_mem_stage_lsu;
  import Pipe_Buf_Reg_PKG::*;

  localparam int ADDR_W = 9;

  logic              clk;
  logic              reset;
  ex_mem_reg         ex_mem_i;
  logic              ex_mem_valid_i;
  logic              stall_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [3:0]        mem_be_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i;
  logic              mem_ack_i;
  mem_wb_reg         mem_wb_o;
  logic              mem_wb_valid_o;
`ifdef LSU_MISALIGN_TRAP_EN
  logic              misalign_o;
`endif

  int errors = 0;
  int checks = 0;
  mem_wb_reg sbq[$];
  mem_wb_reg mw;

  mem_stage_lsu #(.ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .ex_mem_i       (ex_mem_i),
    .ex_mem_valid_i (ex_mem_valid_i),
    .stall_o        (stall_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_be_o       (mem_be_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata_i),
    .mem_ack_i      (mem_ack_i),
    .mem_wb_o       (mem_wb_o),
    .mem_wb_valid_o (mem_wb_valid_o)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .misalign_o     (misalign_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic ex_mem_reg mk(input logic rd, input logic wr,
      input logic rw, input logic [2:0] f3, input logic [31:0] a,
      input logic [31:0] d, input logic [4:0] rdst);
    ex_mem_reg e;
    e            = '0;
    e.MemRead    = rd;
    e.MemWrite   = wr;
    e.RegWrite   = rw;
    e.MemtoReg   = rd;
    e.func3      = f3;
    e.Alu_Result = a;
    e.RD_Two     = d;
    e.RDest      = rdst;
    return e;
  endfunction

  function automatic mem_wb_reg exp_wb(input ex_mem_reg e,
      input logic rw, input logic [31:0] rdat);
    mem_wb_reg w;
    w             = '0;
    w.RegWrite    = rw;
    w.MemtoReg    = e.MemtoReg;
    w.RDest       = e.RDest;
    w.Alu_Result  = e.Alu_Result;
    w.MemReadData = rdat;
    return w;
  endfunction

  always @(negedge clk) begin
    if (reset && mem_wb_valid_o) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_wb", 32'd1, 32'd0);
      end else begin
        mw = sbq.pop_front();
        chk("wb_alu", mem_wb_o.Alu_Result, mw.Alu_Result);
        chk("wb_rdata", mem_wb_o.MemReadData, mw.MemReadData);
        chk("wb_regwrite", {31'd0, mem_wb_o.RegWrite}, {31'd0, mw.RegWrite});
        chk("wb_rdest", {27'd0, mem_wb_o.RDest}, {27'd0, mw.RDest});
      end
    end
  end

  task automatic do_alu(input ex_mem_reg e);
    @(negedge clk);
    ex_mem_i = e;
    ex_mem_valid_i = 1'b1;
    #1;
    chk("alu_stall", {31'd0, stall_o}, 32'd0);
    chk("alu_req", {31'd0, mem_req_o}, 32'd0);
    sbq.push_back(exp_wb(e, e.RegWrite, 32'd0));
    @(posedge clk);
    #1;
    ex_mem_valid_i = 1'b0;
  endtask

  task automatic do_mem(input string tg, input ex_mem_reg e,
      input int wait_n, input logic [31:0] rdata,
      input logic [ADDR_W-1:0] ea, input logic [3:0] ebe,
      input logic [31:0] ewd, input logic [31:0] erd);
    int nst;
    nst = 0;
    @(negedge clk);
    ex_mem_i = e;
    ex_mem_valid_i = 1'b1;
    #1;
    if (stall_o) nst++;
    sbq.push_back(exp_wb(e, e.RegWrite, erd));
    @(posedge clk);
    #1;
    chk({tg, "_req"}, {31'd0, mem_req_o}, 32'd1);
    chk({tg, "_we"}, {31'd0, mem_we_o}, {31'd0, e.MemWrite});
    chk({tg, "_addr"}, {23'd0, mem_addr_o}, {23'd0, ea});
    chk({tg, "_be"}, {28'd0, mem_be_o}, {28'd0, ebe});
    if (e.MemWrite) chk({tg, "_wdata"}, mem_wdata_o, ewd);
    chk({tg, "_wbv_busy"}, {31'd0, mem_wb_valid_o}, 32'd0);
    repeat (wait_n) begin
      @(negedge clk);
      #1;
      if (stall_o) nst++;
      chk({tg, "_req_hold"}, {31'd0, mem_req_o}, 32'd1);
      chk({tg, "_addr_hold"}, {23'd0, mem_addr_o}, {23'd0, ea});
    end
    @(negedge clk);
    mem_ack_i = 1'b1;
    mem_rdata_i = rdata;
    #1;
    chk({tg, "_ack_stall"}, {31'd0, stall_o}, 32'd0);
    @(posedge clk);
    #1;
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    ex_mem_valid_i = 1'b0;
    chk({tg, "_req_drop"}, {31'd0, mem_req_o}, 32'd0);
    chk({tg, "_stall_cyc"}, nst, wait_n + 1);
  endtask

  initial begin
    reset = 1'b0;
    ex_mem_i = '0;
    ex_mem_valid_i = 1'b0;
    mem_rdata_i = '0;
    mem_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wbv", {31'd0, mem_wb_valid_o}, 32'd0);
    chk("rst_wb", {31'd0, |mem_wb_o}, 32'd0);
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_we", {31'd0, mem_we_o}, 32'd0);
    chk("rst_be", {28'd0, mem_be_o}, 32'd0);
    chk("rst_addr", {23'd0, mem_addr_o}, 32'd0);
    chk("rst_wdata", mem_wdata_o, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    reset = 1'b1;

    // bubble carrying RegWrite=1 must not write back
    @(negedge clk);
    ex_mem_i = mk(1'b0, 1'b0, 1'b1, F3_W, 32'h55, 32'h0, 5'd3);
    ex_mem_valid_i = 1'b0;
    @(posedge clk);
    #1;
    chk("bub_wbv", {31'd0, mem_wb_valid_o}, 32'd0);
    chk("bub_rw", {31'd0, mem_wb_o.RegWrite}, 32'd0);
    chk("bub_req", {31'd0, mem_req_o}, 32'd0);
    chk("bub_stall", {31'd0, stall_o}, 32'd0);

    do_alu(mk(1'b0, 1'b0, 1'b1, F3_W, 32'h1234, 32'h0, 5'd7));
    do_alu(mk(1'b0, 1'b0, 1'b1, F3_W, 32'hCAFE_0001, 32'h0, 5'd9));

    do_mem("lb", mk(1'b1, 1'b0, 1'b1, F3_B, 32'h013, 32'h0, 5'd1),
           3, 32'h80FF_FF00, 9'h010, 4'hF, 32'h0, 32'hFFFF_FF80);
    do_mem("sh", mk(1'b0, 1'b1, 1'b0, F3_H, 32'h006, 32'hDEAD_BEEF, 5'd0),
           1, 32'h0, 9'h004, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    do_mem("lbu", mk(1'b1, 1'b0, 1'b1, F3_BU, 32'h011, 32'h0, 5'd2),
           0, 32'h80FF_FF00, 9'h010, 4'hF, 32'h0, 32'h0000_00FF);
    do_mem("lh", mk(1'b1, 1'b0, 1'b1, F3_H, 32'h002, 32'h0, 5'd4),
           0, 32'h80FF_FF00, 9'h000, 4'hF, 32'h0, 32'hFFFF_80FF);
    do_mem("lhu", mk(1'b1, 1'b0, 1'b1, F3_HU, 32'h0F0, 32'h0, 5'd5),
           2, 32'h80FF_FF00, 9'h0F0, 4'hF, 32'h0, 32'h0000_FF00);
    do_mem("sb", mk(1'b0, 1'b1, 1'b0, F3_B, 32'h1FD, 32'h0000_00A5, 5'd0),
           0, 32'h0, 9'h1FC, 4'b0010, 32'hA5A5_A5A5, 32'h0);
    do_mem("sw_wrap", mk(1'b0, 1'b1, 1'b0, F3_W, 32'h0000_0208, 32'h0123_4567, 5'd0),
           0, 32'h0, 9'h008, 4'hF, 32'h0123_4567, 32'h0);
    do_mem("rdwr", mk(1'b1, 1'b1, 1'b0, F3_W, 32'h00C, 32'h7777_0000, 5'd6),
           0, 32'hFFFF_FFFF, 9'h00C, 4'hF, 32'h7777_0000, 32'h0);
    do_mem("lw", mk(1'b1, 1'b0, 1'b1, 3'b111, 32'h044, 32'h0, 5'd8),
           0, 32'h1357_9BDF, 9'h044, 4'hF, 32'h0, 32'h1357_9BDF);

    // reset in the middle of a transaction, then a stray ack in idle
    @(negedge clk);
    ex_mem_i = mk(1'b1, 1'b0, 1'b1, F3_W, 32'h040, 32'h0, 5'd10);
    ex_mem_valid_i = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_req_pre", {31'd0, mem_req_o}, 32'd1);
    ex_mem_valid_i = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_req", {31'd0, mem_req_o}, 32'd0);
    chk("abort_wbv", {31'd0, mem_wb_valid_o}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'hBAD0_BAD0;
    #1;
    chk("late_ack_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk);
    #1;
    mem_ack_i = 1'b0;
    chk("late_ack_req", {31'd0, mem_req_o}, 32'd0);
    chk("late_ack_wbv", {31'd0, mem_wb_valid_o}, 32'd0);

    do_alu(mk(1'b0, 1'b0, 1'b1, F3_W, 32'h0000_ABCD, 32'h0, 5'd11));

`ifdef LSU_MISALIGN_TRAP_EN
    @(negedge clk);
    ex_mem_i = mk(1'b1, 1'b0, 1'b1, F3_W, 32'h002, 32'h0, 5'd12);
    ex_mem_valid_i = 1'b1;
    #1;
    chk("mis_stall", {31'd0, stall_o}, 32'd0);
    sbq.push_back(exp_wb(ex_mem_i, 1'b0, 32'h0));
    @(posedge clk);
    #1;
    ex_mem_valid_i = 1'b0;
    chk("mis_flag", {31'd0, misalign_o}, 32'd1);
    chk("mis_req", {31'd0, mem_req_o}, 32'd0);
    @(posedge clk);
    #1;
    chk("mis_flag_drop", {31'd0, misalign_o}, 32'd0);
    chk("mis_req_after", {31'd0, mem_req_o}, 32'd0);
`else
    do_mem("lw_mis", mk(1'b1, 1'b0, 1'b1, F3_W, 32'h002, 32'h0, 5'd12),
           0, 32'h1122_3344, 9'h000, 4'hF, 32'h0, 32'h1122_3344);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sbq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
